// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package arb_types;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ICACHE, ARB_DCACHE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

  localparam int PERF_W = 32;

  function automatic arb_owner_t owner_of(input arb_state_t s);
    case (s)
      ARB_ICACHE: return OWN_I;
      ARB_DCACHE: return OWN_D;
      default:    return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_perf_counters.sv
// Wrapping grant and conflict event counters for the memory arbiter.
module arb_perf_counters
  import arb_types::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_i,
  input  logic              grant_d,
  input  logic              conflict,
  output logic [PERF_W-1:0] perf_i_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_i)  perf_i_grants  <= perf_i_grants + 1'b1;
      if (grant_d)  perf_d_grants  <= perf_d_grants + 1'b1;
      if (conflict) perf_conflicts <= perf_conflicts + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single physical-memory line port between I-cache and D-cache misses.
// Define ARB_PERF_CNT_EN to enable the perf_* grant/conflict counters (tied to 0 otherwise).
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [PERF_W-1:0] perf_i_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
);

  localparam int RUN_W = $clog2(MAX_D_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

  arb_state_t       state, state_nxt;
  arb_owner_t       owner;
  logic [RUN_W-1:0] d_run;
  logic             d_req, grant_i, grant_d;

  assign d_req = d_pmem_read | d_pmem_write;
  assign owner = owner_of(state);

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      ARB_IDLE: begin
        // D is favoured; I only wins once D has used up its run budget.
        if (d_req && !(i_pmem_read && d_run == RUN_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = ARB_DCACHE;
        end else if (i_pmem_read) begin
          grant_i   = 1'b1;
          state_nxt = ARB_ICACHE;
        end
      end
      ARB_ICACHE, ARB_DCACHE: if (pmem_resp) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         d_run <= '0;
    else if (!i_pmem_read || grant_i)   d_run <= '0;
    else if (grant_d && d_run != RUN_MAX) d_run <= d_run + 1'b1;
  end

  // Command registers: loaded on grant, held while busy, dropped after resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else if (grant_d) begin
      pmem_read    <= d_pmem_read & ~d_pmem_write;
      pmem_write   <= d_pmem_write;
      pmem_address <= d_pmem_address;
      pmem_wdata   <= d_pmem_wdata;
    end else if (grant_i) begin
      pmem_read    <= 1'b1;
      pmem_write   <= 1'b0;
      pmem_address <= i_pmem_address;
    end else if (state != ARB_IDLE && pmem_resp) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end
  end

  assign i_pmem_resp  = pmem_resp && (owner == OWN_I);
  assign d_pmem_resp  = pmem_resp && (owner == OWN_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .grant_i        (grant_i),
    .grant_d        (grant_d),
    .conflict       (grant_d & i_pmem_read),
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
  );
`else
  assign perf_i_grants  = '0;
  assign perf_d_grants  = '0;
  assign perf_conflicts = '0;
`endif

  // Requesters must hold request and address until their transaction completes.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_ICACHE && !pmem_resp) |-> (i_pmem_read && i_pmem_address == pmem_address));
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_DCACHE && !pmem_resp) |-> (d_req && d_pmem_address == pmem_address));
  a_d_rw: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected grants queued by the stimulus, checked at the memory port.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic [31:0]       perf_i_grants, perf_d_grants, perf_conflicts;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_D_RUN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_d;
    bit              wr;
    logic [31:0]     addr;
    logic [255:0]    wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic txn_t mk(input bit is_d, input bit wr, input logic [31:0] a);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = {32{8'hA5}};
    return t;
  endfunction

  // Memory model: answers after mem_lat command cycles; spur injects a stray resp.
  int mem_lat = 5;
  bit spur = 1'b0;
  int mcnt = 0;
  initial forever begin
    @(negedge clk);
    pmem_resp = 1'b0;
    if (!rst_n) mcnt = 0;
    else if (spur) begin
      pmem_resp = 1'b1;
      pmem_rdata = line_of(32'hDEAD_BEEF);
    end else if (pmem_read || pmem_write) begin
      mcnt++;
      if (mcnt >= mem_lat) begin
        pmem_resp = 1'b1;
        pmem_rdata = line_of(pmem_address);
        mcnt = 0;
      end
    end else mcnt = 0;
  end

  // Monitor: pops the expected grant on each new command and checks response routing.
  int   cyc = 0, last_resp_cyc = 0, gap_i = 0;
  int   m_i = 0, m_d = 0, m_c = 0;
  bit   cur_v = 1'b0, prev_cmd = 1'b0;
  txn_t cur;
  initial forever begin
    @(negedge clk); #1;
    cyc++;
    if (!rst_n) begin
      cur_v = 1'b0; prev_cmd = 1'b0; m_i = 0; m_d = 0; m_c = 0;
    end else begin
      if ((pmem_read || pmem_write) && !prev_cmd) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 256'(pmem_address), 256'hFFFF_FFFF_FFFF);
        else begin
          cur = exp_q.pop_front();
          cur_v = 1'b1;
          chk("grant_write", 256'(pmem_write), 256'(cur.wr));
          chk("grant_read", 256'(pmem_read), 256'(!cur.wr));
          chk("grant_addr", 256'(pmem_address), 256'(cur.addr));
          if (cur.wr) chk("grant_wdata", pmem_wdata, cur.wdata);
          if (cur.is_d) begin
            m_d++;
            if (i_pmem_read) m_c++;
          end else begin
            m_i++;
            gap_i = cyc - last_resp_cyc;
          end
        end
      end
      prev_cmd = pmem_read || pmem_write;
      if (pmem_resp || i_pmem_resp || d_pmem_resp) begin
        chk("i_resp", 256'(i_pmem_resp), 256'(cur_v && !cur.is_d && pmem_resp));
        chk("d_resp", 256'(d_pmem_resp), 256'(cur_v && cur.is_d && pmem_resp));
        if (cur_v && pmem_resp) begin
          if (cur.is_d) chk("d_rdata", d_pmem_rdata, line_of(cur.addr));
          else          chk("i_rdata", i_pmem_rdata, line_of(cur.addr));
          cur_v = 1'b0;
          last_resp_cyc = cyc;
        end
      end
    end
  end

  // Waits (bounded) for this requester's resp; returns just after the sample point.
  task automatic wait_resp(input bit is_d);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!(is_d ? d_pmem_resp : i_pmem_resp) && t < 200);
    if (!(is_d ? d_pmem_resp : i_pmem_resp)) chk(is_d ? "d_timeout" : "i_timeout", 256'(0), 256'(1));
    #1;
  endtask

  task automatic i_req(input logic [31:0] a);
    i_pmem_read = 1'b1; i_pmem_address = a;
    wait_resp(1'b0);
    i_pmem_read = 1'b0;
  endtask

  task automatic d_reqs(input int n, input logic [31:0] base, input bit wr);
    for (int k = 0; k < n; k++) begin
      d_pmem_read = !wr; d_pmem_write = wr;
      d_pmem_address = base + 32'(k) * 32'h20;
      d_pmem_wdata = {32{8'hA5}};
      wait_resp(1'b1);
    end
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
  endtask

  task automatic align();
    @(negedge clk); #2;
  endtask

  task automatic chk_perf(input string tag, input int ei, input int ed, input int ec);
`ifdef ARB_PERF_CNT_EN
    chk({tag, "_perf_i"}, 256'(perf_i_grants), 256'(ei));
    chk({tag, "_perf_d"}, 256'(perf_d_grants), 256'(ed));
    chk({tag, "_perf_c"}, 256'(perf_conflicts), 256'(ec));
`else
    chk({tag, "_perf_i"}, 256'(perf_i_grants), 256'(0));
    chk({tag, "_perf_d"}, 256'(perf_d_grants), 256'(0));
    chk({tag, "_perf_c"}, 256'(perf_conflicts), 256'(0));
`endif
  endtask

  initial begin
    int t;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read", 256'(pmem_read), 256'(0));
    chk("rst_write", 256'(pmem_write), 256'(0));
    chk("rst_addr", 256'(pmem_address), 256'(0));
    chk("rst_wdata", pmem_wdata, 256'(0));
    chk_perf("rst", 0, 0, 0);
    #1 rst_n = 1'b1;

    // I read alone: command next cycle, resp after 5 cycles, single-cycle pulse.
    align();
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0060));
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
    @(negedge clk); #1;
    chk("t1_read_next", 256'(pmem_read), 256'(1));
    chk("t1_addr_next", 256'(pmem_address), 256'h60);
    t = 1;
    while (!i_pmem_resp && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("t1_resp_lat", 256'(t), 256'(5));
    chk("t1_d_resp", 256'(d_pmem_resp), 256'(0));
    #1 i_pmem_read = 1'b0;
    @(negedge clk); #1;
    chk("t1_resp_pulse", 256'(i_pmem_resp), 256'(0));

    // Simultaneous I read and D write: D first, I two cycles after D resp.
    align();
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0100));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0200));
    fork
      d_reqs(1, 32'h0000_0100, 1'b1);
      i_req(32'h0000_0200);
    join
    chk("t2_i_gap", 256'(gap_i), 256'(2));

    // Starvation bound: I held while D streams -> D,D,D,D,I,D.
    align();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, 32'h1000 + 32'(k) * 32'h20));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0300));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h1080));
    fork
      d_reqs(5, 32'h0000_1000, 1'b0);
      i_req(32'h0000_0300);
    join
    align();
    chk("t3_queue_empty", 256'(exp_q.size()), 256'(0));
    chk_perf("t3", 3, 6, 5);
    chk("t3_model_i", 256'(m_i), 256'(3));
    chk("t3_model_c", 256'(m_c), 256'(5));

    // Reset during a D read aborts the transaction.
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0400));
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0400;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_read_abort", 256'(pmem_read), 256'(0));
    chk("t4_write_abort", 256'(pmem_write), 256'(0));
    chk("t4_i_resp", 256'(i_pmem_resp), 256'(0));
    chk("t4_d_resp", 256'(d_pmem_resp), 256'(0));
    chk_perf("t4", 0, 0, 0);
    d_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("t4_queue_empty", 256'(exp_q.size()), 256'(0));
    align();
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0500));
    i_req(32'h0000_0500);

    // Spurious resp while idle: no resp routed, no command issued.
    align();
    spur = 1'b1;
    @(negedge clk); #2;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_idle_read", 256'(pmem_read), 256'(0));
    chk("t5_idle_write", 256'(pmem_write), 256'(0));
    align();
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0600));
    i_req(32'h0000_0600);
    align();
    chk("t5_queue_empty", 256'(exp_q.size()), 256'(0));
    chk_perf("end", 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
